// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-PC controller: control-transfer encodings,
// default address map and small address helpers.
package pc_ctrl_pkg;

  // Control-transfer kind of the instruction sitting in D.
  typedef enum logic [1:0] {
    BOP_NONE   = 2'd0,
    BOP_BRANCH = 2'd1,
    BOP_JIDX   = 2'd2,
    BOP_JREG   = 2'd3
  } bop_e;

  // Default address map.
  localparam logic [31:0] RESET_PC_DFLT  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DFLT = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DFLT     = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DFLT     = 32'h0000_6ffc;

  // Instruction size in bytes.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Sign-extended, word-scaled branch displacement.
  function automatic logic [31:0] branch_disp(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

  // Fetch address fault: misaligned or outside the inclusive window [lo, hi].
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    logic w_misaligned;
    logic w_below;
    logic w_above;
    w_misaligned = (pc[1:0] != 2'b00);
    w_below      = (pc < lo);
    w_above      = (pc > hi);
    return w_misaligned | w_below | w_above;
  endfunction

endpackage

// File: rtl/pc_ctrl_npc.sv
// Combinational D-stage target resolver: computes the control-transfer
// target, whether the transfer redirects fetch, and whether the D
// instruction is any control transfer at all (which marks a delay slot).
module npc_calc
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] i_d_pc,
  input  logic [1:0]  i_d_bop,
  input  logic        i_d_cmp,
  input  logic [15:0] i_d_imm16,
  input  logic [25:0] i_d_imm26,
  input  logic [31:0] i_d_rs,
  output logic [31:0] o_target,
  output logic        o_redirect,
  output logic        o_is_cti
);

  logic [31:0] w_seq;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

  // Sequential address after D and the two immediate-based targets; all
  // arithmetic wraps modulo 2^32, no overflow is ever trapped.
  always_comb begin
    w_seq       = i_d_pc + INSTR_BYTES;
    w_br_target = w_seq + branch_disp(i_d_imm16);
    w_j_target  = {w_seq[31:28], i_d_imm26, 2'b00};
  end

  // Select the target and decide redirect by transfer kind; the jump-register
  // target is passed through untouched so a bad address surfaces at fetch.
  always_comb begin
    o_target   = w_seq;
    o_redirect = 1'b0;
    o_is_cti   = 1'b0;
    case (bop_e'(i_d_bop))
      BOP_NONE: begin
        o_target   = w_seq;
        o_redirect = 1'b0;
        o_is_cti   = 1'b0;
      end
      BOP_BRANCH: begin
        o_target   = w_br_target;
        o_redirect = i_d_cmp;
        o_is_cti   = 1'b1;
      end
      BOP_JIDX: begin
        o_target   = w_j_target;
        o_redirect = 1'b1;
        o_is_cti   = 1'b1;
      end
      BOP_JREG: begin
        o_target   = i_d_rs;
        o_redirect = 1'b1;
        o_is_cti   = 1'b1;
      end
      default: begin
        o_target   = w_seq;
        o_redirect = 1'b0;
        o_is_cti   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch program-counter controller: holds F_pc and the delay-slot flag and
// arbitrates between reset, exception entry, ERET, stall, redirect and the
// sequential path. The address-error flag is decoded straight from F_pc.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DFLT,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DFLT,
  parameter logic [31:0] IM_LO     = IM_LO_DFLT,
  parameter logic [31:0] IM_HI     = IM_HI_DFLT
)
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic [31:0] i_d_pc,
  input  logic [1:0]  i_d_bop,
  input  logic        i_d_cmp,
  input  logic [15:0] i_d_imm16,
  input  logic [25:0] i_d_imm26,
  input  logic [31:0] i_d_rs,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  output logic [31:0] o_f_pc,
  output logic        o_f_bd,
  output logic        o_f_adel
);

  logic [31:0] r_f_pc;
  logic        r_f_bd;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_is_cti;
  logic [31:0] w_f_seq;

  npc_calc u_npc_calc (
    .i_d_pc     (i_d_pc),
    .i_d_bop    (i_d_bop),
    .i_d_cmp    (i_d_cmp),
    .i_d_imm16  (i_d_imm16),
    .i_d_imm26  (i_d_imm26),
    .i_d_rs     (i_d_rs),
    .o_target   (w_target),
    .o_redirect (w_redirect),
    .o_is_cti   (w_is_cti)
  );

  // Sequential fetch successor; wraps past the top of the address space.
  always_comb begin
    w_f_seq = r_f_pc + INSTR_BYTES;
  end

  // PC and delay-slot register update: reset, then exception, then ERET
  // (both able to break a stall), then stall hold, then redirect or +4.
  // The delay-slot flag follows any control transfer in D, taken or not.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_f_pc <= RESET_PC;
      r_f_bd <= 1'b0;
    end else if (i_exc_req) begin
      r_f_pc <= EXC_ENTRY;
      r_f_bd <= 1'b0;
    end else if (i_eret_req) begin
      r_f_pc <= i_epc;
      r_f_bd <= 1'b0;
    end else if (i_stall) begin
      r_f_pc <= r_f_pc;
      r_f_bd <= r_f_bd;
    end else if (w_redirect) begin
      r_f_pc <= w_target;
      r_f_bd <= w_is_cti;
    end else begin
      r_f_pc <= w_f_seq;
      r_f_bd <= w_is_cti;
    end
  end

  // Address-error decode of the current fetch address; purely observational,
  // sequencing is left to the exception request that eventually follows.
  always_comb begin
    o_f_adel = fetch_fault(r_f_pc, IM_LO, IM_HI);
  end

  // Registered outputs.
  always_comb begin
    o_f_pc = r_f_pc;
    o_f_bd = r_f_bd;
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a table of one-cycle vectors with hand-computed
// expected F_pc / F_bd / F_adel, followed by hand-written multi-cycle checks.
module tb_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] d_pc;
  logic [1:0]  d_bop;
  logic        d_cmp;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] f_pc;
  logic        f_bd;
  logic        f_adel;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [31:0] dpc;
    logic [1:0]  bop;
    logic        cmp;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
    logic        exc;
    logic        eret;
    logic [31:0] epcv;
    logic [31:0] e_pc;
    logic        e_bd;
    logic        e_adel;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs[NVEC];

  pc_ctrl dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_stall    (stall),
    .i_d_pc     (d_pc),
    .i_d_bop    (d_bop),
    .i_d_cmp    (d_cmp),
    .i_d_imm16  (d_imm16),
    .i_d_imm26  (d_imm26),
    .i_d_rs     (d_rs),
    .i_exc_req  (exc_req),
    .i_eret_req (eret_req),
    .i_epc      (epc),
    .o_f_pc     (f_pc),
    .o_f_bd     (f_bd),
    .o_f_adel   (f_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic stl, input logic [31:0] dpc,
                              input logic [1:0] bop, input logic cmp, input logic [15:0] i16,
                              input logic [25:0] i26, input logic [31:0] rs, input logic exc,
                              input logic eret, input logic [31:0] epcv, input logic [31:0] e_pc,
                              input logic e_bd, input logic e_adel);
    vec_t v;
    v.rst = rst; v.stl = stl; v.dpc = dpc; v.bop = bop; v.cmp = cmp;
    v.i16 = i16; v.i26 = i26; v.rs = rs; v.exc = exc; v.eret = eret;
    v.epcv = epcv; v.e_pc = e_pc; v.e_bd = e_bd; v.e_adel = e_adel;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; d_pc = v.dpc; d_bop = v.bop; d_cmp = v.cmp;
    d_imm16 = v.i16; d_imm26 = v.i26; d_rs = v.rs; exc_req = v.exc;
    eret_req = v.eret; epc = v.epcv;
  endtask

  task automatic idle();
    drive(mk(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0,
             32'h0, 1'b0, 1'b0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //               rst   stl   d_pc          bop   cmp   imm16     imm26         rs            exc   eret  epc           exp_pc        bd    adel
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3004, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3008, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_300c, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h3010,     2'd1, 1'b1, 16'hfffe, 26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_300c, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h3010,     2'd1, 1'b0, 16'hfffe, 26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3010, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3014, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h3020,     2'd2, 1'b0, 16'h0,    26'h0001000,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_4000, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h4000,     2'd3, 1'b0, 16'h0,    26'h0,        32'h3001,     1'b0, 1'b0, 32'h0,        32'h0000_3001, 1'b1, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3005, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 1'b1, 32'h3020,     2'd2, 1'b0, 16'h0,    26'h0001000,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3005, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 1'b1, 32'h3020,     2'd2, 1'b0, 16'h0,    26'h0001000,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3005, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 1'b1, 32'h3020,     2'd2, 1'b0, 16'h0,    26'h0001000,  32'h0,        1'b1, 1'b0, 32'h0,        32'h0000_4180, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b1, 1'b1, 32'h3040,     32'h0000_4180, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 32'h3020,     2'd2, 1'b0, 16'h0,    26'h0001000,  32'h0,        1'b0, 1'b1, 32'h3040,     32'h0000_3040, 1'b0, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 32'h3020,     2'd2, 1'b0, 16'h0,    26'h0001000,  32'h0,        1'b1, 1'b0, 32'h0,        32'h0000_3000, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 32'h3000,     2'd3, 1'b0, 16'h0,    26'h0,        32'h6ffc,     1'b0, 1'b0, 32'h0,        32'h0000_6ffc, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_7000, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 1'b0, 32'h3000,     2'd3, 1'b0, 16'h0,    26'h0,        32'hffff_fffc, 1'b0, 1'b0, 32'h0,       32'hffff_fffc, 1'b1, 1'b1);
    vecs[19] = mk(1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b1);
    vecs[20] = mk(1'b0, 1'b0, 32'h3000,     2'd3, 1'b0, 16'h0,    26'h0,        32'h2ffc,     1'b0, 1'b0, 32'h0,        32'h0000_2ffc, 1'b1, 1'b1);
    vecs[21] = mk(1'b0, 1'b0, 32'h3000,     2'd3, 1'b0, 16'h0,    26'h0,        32'h3000,     1'b0, 1'b0, 32'h0,        32'h0000_3000, 1'b1, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 32'h0,        2'd1, 1'b1, 16'h8000, 26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'hfffe_0004, 1'b1, 1'b1);
    vecs[23] = mk(1'b0, 1'b1, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'hfffe_0004, 1'b1, 1'b1);
    vecs[24] = mk(1'b0, 1'b1, 32'h0,        2'd0, 1'b0, 16'h0,    26'h0,        32'h0,        1'b0, 1'b1, 32'h3100,     32'h0000_3100, 1'b0, 1'b0);
    vecs[25] = mk(1'b0, 1'b0, 32'h3100,     2'd1, 1'b1, 16'h0010, 26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3144, 1'b1, 1'b0);
    vecs[26] = mk(1'b1, 1'b1, 32'h3100,     2'd1, 1'b1, 16'h0010, 26'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3000, 1'b0, 1'b0);
    vecs[27] = mk(1'b0, 1'b0, 32'h9fff_fffc, 2'd2, 1'b0, 16'h0,   26'h3ffffff,  32'h0,        1'b0, 1'b0, 32'h0,        32'hafff_fffc, 1'b1, 1'b1);

    idle();
    reset = 1'b1;
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      step();
      chk32($sformatf("vec%0d_f_pc", i), f_pc, vecs[i].e_pc);
      chk1($sformatf("vec%0d_f_bd", i), f_bd, vecs[i].e_bd);
      chk1($sformatf("vec%0d_f_adel", i), f_adel, vecs[i].e_adel);
    end

    // Sequence: reset, then a JREG presented mid-cycle must not reach F_pc
    // before the edge; a 3-cycle stall freezes it, release lets it through.
    idle();
    reset = 1'b1;
    step();
    chk32("seq_reset_pc", f_pc, 32'h0000_3000);
    idle();
    d_bop = 2'd3;
    d_rs  = 32'h0000_5000;
    #2;
    chk32("seq_no_comb_path", f_pc, 32'h0000_3000);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk32($sformatf("seq_stall%0d_pc", k), f_pc, 32'h0000_3000);
      chk1($sformatf("seq_stall%0d_bd", k), f_bd, 1'b0);
    end
    stall = 1'b0;
    step();
    chk32("seq_release_pc", f_pc, 32'h0000_5000);
    chk1("seq_release_bd", f_bd, 1'b1);

    // Not-taken branch in D: sequential fetch, delay-slot flag still set,
    // then a plain cycle clears it.
    idle();
    d_pc  = 32'h0000_5000;
    d_bop = 2'd1;
    d_cmp = 1'b0;
    d_imm16 = 16'h0100;
    step();
    chk32("seq_nt_pc", f_pc, 32'h0000_5004);
    chk1("seq_nt_bd", f_bd, 1'b1);
    idle();
    step();
    chk32("seq_after_nt_pc", f_pc, 32'h0000_5008);
    chk1("seq_after_nt_bd", f_bd, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
